la_dmuxreg: RTL and testbench
=============================

// Module: la_dmuxreg
//
// PURPOSE
//  N-input, W-bit one-hot data mux with a registered, flow-controlled output.
//  Output is the bitwise OR of the inputs whose select bits are set.
//  Input and output use valid/ready handshakes, with a 2-entry skid buffer so the
//  block sustains full throughput under backpressure.
//  Sits between N producers that are arbitrated elsewhere (e.g. by an arbiter's grant)
//  and one consumer. It replaces fixed-width combinational dmux cells on timing-critical paths.
//
// PARAMETERS
//  N     5          number of input channels (>=2)
//  W     1          data width per channel (>=1)
//  CW    8          width of the error counter
//  PROP  "DEFAULT"  cell property, passed through to implementation
//
// PORTS
//  clk        in   1    clock
//  nreset     in   1    asynchronous active-low reset
//  sel        in   N    select, expected one-hot; sel[i] chooses in[i*W+:W]
//  in         in   N*W  packed channel data, channel 0 in LSBs
//  in_valid   in   1    sel/in valid
//  in_ready   out  1    block can accept
//  out        out  W    muxed data
//  out_valid  out  1    out holds a result
//  out_ready  in   1    consumer accepts
//  err        out  1    sticky: a non-one-hot sel was accepted
//  err_cnt    out  CW   count of non-one-hot accepts, saturating
//  err_clr    in   1    synchronous clear of err and err_cnt
//
// BEHAVIOUR
//  - Reset (async assert, sync release): out=0, out_valid=0, skid empty, err=0, err_cnt=0.
//    in_ready=1 from the first cycle after release.
//  - Accept: in_valid & in_ready. Result = OR over i of ({W{sel[i]}} & in[i]).
//    Zero-hot sel gives 0; multi-hot sel gives the OR of the selected channels.
//  - Latency: an accepted word appears on out, with out_valid=1, the cycle after acceptance.
//  - Output transfer: out_valid & out_ready. out/out_valid must hold stable until the transfer.
//  - Skid: if the output register is full and out_ready=0, an accepted word goes to the skid register.
//    in_ready = !skid_full, driven from a register (no combinational in->out ready path).
//    When the output is popped, the skid entry moves to the output in that same cycle.
//  - Simultaneous accept and output pop with skid empty: the new word loads the output register; no bubble.
//  - Full (both registers occupied): in_ready=0. Input is ignored until a pop.
//  - Ordering strictly FIFO. No word is lost or duplicated.
//  - Mid-operation reset: all in-flight words are discarded and the outputs return to their reset values.
//
// CONFIGURATION
//  LA_DMUXREG_ERRCHK_EN defined:
//   - On each accept with popcount(sel)!=1: err<=1 and err_cnt<=err_cnt+1, saturating at 2^CW-1.
//   - err_clr=1 clears err and err_cnt the next cycle.
//   - If err_clr and a violation occur in the same cycle, the violation wins: err=1, err_cnt=1.
//  LA_DMUXREG_ERRCHK_EN undefined: err and err_cnt are tied to 0, err_clr is ignored, and no check logic is built.
//
// STRUCTURE
//  - Shared package la_dmux_pkg:
//    - localparam function for the popcount/one-hot check;
//    - onehot-OR reduction function (sel, packed in) -> W;
//    - error-counter saturation constant.
//  - Sub-module la_skid2 (W-bit, 2-entry valid/ready skid buffer) carries the registered datapath.
//    la_dmuxreg = mux function + la_skid2 + optional checker.
//
// TESTING
//  1. N=5,W=8: sel=5'b00100, in[2]=8'hA5, out_ready=1 -> next cycle out=8'hA5, out_valid=1, err=0.
//  2. Streaming: 100 back-to-back words with out_ready=1 -> one word per cycle, in order, in_ready stays 1.
//  3. Backpressure: hold out_ready=0 and send 3 words -> first 2 held (out=word0), in_ready=0 after the 2nd;
//     release -> word0, word1 in order, no loss.
//  4. sel=5'b00000 -> out=0. sel=5'b00011, in0=8'h0F, in1=8'hF0 -> out=8'hFF.
//     With ERRCHK_EN: err=1, err_cnt=2. Without: err=0.
//  5. ERRCHK_EN, CW=2: 5 multi-hot accepts -> err_cnt saturates at 3.
//     err_clr alone -> 0. err_clr together with a violation -> err_cnt=1.
//  6. Assert nreset with 2 words buffered -> out_valid=0, out=0, err=0 immediately.
//     After release, in_ready=1 and the next word passes with 1-cycle latency.

Source files
------------

// File: rtl/la_dmux_pkg.sv
// Shared types and helpers for la_dmuxreg and its skid buffer.
//  - skid_state_e : occupancy state of the 2-entry skid buffer
//  - popcount / is_onehot : select-vector population check
//  - onehot_or : OR of all selected channels of a packed channel vector
//  - err_cnt_max : saturation value of a CW-bit error counter
// The helpers work on fixed maximum widths (MAX_N channels, MAX_W bits per channel).
// Callers zero-extend their vectors into these widths and truncate the result.
package la_dmux_pkg;

  localparam int unsigned MAX_N      = 32;
  localparam int unsigned MAX_W      = 32;
  localparam int unsigned MAX_NW     = MAX_N * MAX_W;
  localparam int unsigned IDX_W      = $clog2(MAX_NW);
  localparam int unsigned PC_W       = $clog2(MAX_N + 1);
  localparam int unsigned CNT_MAX_CW = 32;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_FULL  = 2'd2
  } skid_state_e;

  // Number of set bits; zero-extension of the argument does not change it.
  function automatic logic [PC_W-1:0] popcount(input logic [MAX_N-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic is_onehot(input logic [MAX_N-1:0] v);
    return popcount(v) == PC_W'(1);
  endfunction

  // Bit b of the result is the OR of bit b of every channel i with sel[i] set.
  // Channel i occupies data[i*w +: w]; channels at or above n are ignored.
  function automatic logic [MAX_W-1:0] onehot_or(input int unsigned      n,
                                                 input int unsigned      w,
                                                 input logic [MAX_N-1:0] sel,
                                                 input logic [MAX_NW-1:0] data);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      for (int unsigned b = 0; b < MAX_W; b++) begin
        if ((i < n) && (b < w) && sel[i]) begin
          r[b] = r[b] | data[IDX_W'(i * w + b)];
        end
      end
    end
    return r;
  endfunction

  // All-ones value of a cw-bit counter, returned in CNT_MAX_CW bits.
  function automatic logic [CNT_MAX_CW-1:0] err_cnt_max(input int unsigned cw);
    return (cw >= CNT_MAX_CW) ? '1
                              : (CNT_MAX_CW'(1) << cw) - CNT_MAX_CW'(1);
  endfunction

endpackage

// File: rtl/la_skid2.sv
// W-bit, 2-entry valid/ready skid buffer with a registered output stage.
// Ports:
//  clk, nreset         clock, asynchronous active-low reset
//  in_data/in_valid    upstream word and its valid
//  in_ready            registered: low only while both entries are occupied
//  out_data/out_valid  registered output word and its valid
//  out_ready           downstream accept
// Words leave in arrival order; a pop refills the output from the skid entry
// in the same cycle, and an accept during a pop with an empty skid goes straight
// to the output, so back-to-back traffic sees no bubble.
module la_skid2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  import la_dmux_pkg::*;

  skid_state_e  r_state;
  skid_state_e  w_state_nxt;
  logic [W-1:0] r_out;
  logic [W-1:0] r_skid;
  logic         r_out_valid;
  logic         r_in_ready;
  logic         w_acc;
  logic         w_pop;
  logic         w_load_out;
  logic         w_out_from_skid;
  logic         w_load_skid;

  assign w_acc = in_valid & r_in_ready;
  assign w_pop = r_out_valid & out_ready;

  // Occupancy state register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= SK_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next occupancy and datapath load strobes.
  always_comb begin
    w_state_nxt     = r_state;
    w_load_out      = 1'b0;
    w_out_from_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      SK_EMPTY: begin
        if (w_acc) begin
          w_load_out  = 1'b1;
          w_state_nxt = SK_ONE;
        end
      end
      SK_ONE: begin
        if (w_acc && w_pop) begin
          w_load_out = 1'b1;
        end else if (w_acc) begin
          w_load_skid = 1'b1;
          w_state_nxt = SK_FULL;
        end else if (w_pop) begin
          w_state_nxt = SK_EMPTY;
        end
      end
      SK_FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (w_pop) begin
          w_out_from_skid = 1'b1;
          w_state_nxt     = SK_ONE;
        end
      end
      default: begin
        w_state_nxt = SK_EMPTY;
      end
    endcase
  end

  // Data and handshake registers; flags track the next occupancy state.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_out       <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      if (w_load_out) begin
        r_out <= in_data;
      end else if (w_out_from_skid) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
      r_out_valid <= (w_state_nxt != SK_EMPTY);
      r_in_ready  <= (w_state_nxt != SK_FULL);
    end
  end

  assign out_data  = r_out;
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;

endmodule

// File: rtl/la_dmuxreg.sv
// N-input, W-bit one-hot OR mux feeding a registered, flow-controlled output.
// Build option: define LA_DMUXREG_ERRCHK_EN to build the non-one-hot select
// checker (err / err_cnt); otherwise err and err_cnt are tied low and err_clr
// is ignored.
// Ports:
//  clk, nreset        clock, asynchronous active-low reset
//  sel[N]             channel select, expected one-hot
//  in[N*W]            packed channel data, channel 0 in the LSBs
//  in_valid/in_ready  input handshake
//  out[W]/out_valid   registered result and its valid, one cycle after accept
//  out_ready          consumer accept
//  err                sticky flag: a non-one-hot select was accepted
//  err_cnt[CW]        saturating count of such accepts
//  err_clr            synchronous clear of err and err_cnt
// Limits: N <= 32, W <= 32, CW <= 32.
module la_dmuxreg #(
  parameter int unsigned N    = 5,
  parameter int unsigned W    = 1,
  parameter int unsigned CW   = 8,
  parameter string       PROP = "DEFAULT"
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [N-1:0]  sel,
  input  logic [N*W-1:0] in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err,
  output logic [CW-1:0] err_cnt,
  input  logic          err_clr
);
  import la_dmux_pkg::*;

  logic [W-1:0] w_mux;
  logic         w_unused_prop;

  // PROP is only a tag for the implementation flow.
  assign w_unused_prop = (PROP != "");

  // Combinational select ahead of the output register.
  assign w_mux = W'(onehot_or(N, W, MAX_N'(sel), MAX_NW'(in)));

  la_skid2 #(
    .W (W)
  ) u_skid (
    .clk       (clk),
    .nreset    (nreset),
    .in_data   (w_mux),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

`ifdef LA_DMUXREG_ERRCHK_EN
  localparam logic [CW-1:0] ERR_MAX = CW'(err_cnt_max(CW));

  logic          w_acc;
  logic          w_viol;
  logic          r_err;
  logic [CW-1:0] r_err_cnt;

  assign w_acc  = in_valid & in_ready;
  assign w_viol = w_acc & ~is_onehot(MAX_N'(sel));

  // A violation outranks a clear in the same cycle, restarting the count at 1.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_viol) begin
      r_err <= 1'b1;
      if (err_clr) begin
        r_err_cnt <= CW'(1);
      end else if (r_err_cnt != ERR_MAX) begin
        r_err_cnt <= r_err_cnt + CW'(1);
      end
    end else if (err_clr) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end
  end

  assign err     = r_err;
  assign err_cnt = r_err_cnt;
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = err_clr;
  assign err              = 1'b0;
  assign err_cnt          = '0;
`endif

endmodule

// File: tb/tb_la_dmuxreg.sv
module tb_la_dmuxreg;
  localparam int unsigned N  = 5;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 2;
`ifdef LA_DMUXREG_ERRCHK_EN
  localparam bit EC = 1'b1;
`else
  localparam bit EC = 1'b0;
`endif
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int NV = 9;

  logic           clk = 1'b0;
  logic           nreset = 1'b0;
  logic [N-1:0]   sel = '0;
  logic [N*W-1:0] din = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   out;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           err;
  logic [CW-1:0]  err_cnt;
  logic           err_clr = 1'b0;

  always #5 clk = ~clk;

  la_dmuxreg #(.N(N), .W(W), .CW(CW), .PROP("DEFAULT")) dut (
    .clk       (clk),
    .nreset    (nreset),
    .sel       (sel),
    .in        (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO of results awaiting transfer plus error state.
  logic [W-1:0] mq[$];
  bit           m_err = 1'b0;
  int           m_cnt = 0;

  typedef struct {
    logic [N-1:0] sel;
    logic         v;
    logic         r;
    logic         c;
    logic [W-1:0] e_out;
    bit           e_ov;
    bit           e_ir;
    bit           e_err;
    int           e_cnt;
  } vec_t;

  vec_t tbl[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_mux(input logic [N-1:0] s, input logic [N*W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (s[i]) r = r | d[i*W +: W];
    end
    return r;
  endfunction

  task automatic model_step(input logic [N-1:0] s, input logic [N*W-1:0] d,
                            input logic v, input logic r, input logic c);
    bit acc;
    bit pop;
    acc = v && (mq.size() < 2);
    pop = (mq.size() > 0) && r;
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(ref_mux(s, d));
    if (EC) begin
      if (acc && ($countones(s) != 1)) begin
        m_err = 1'b1;
        m_cnt = c ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
      end else if (c) begin
        m_err = 1'b0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk({tag, "_out"}, 32'(out), 32'(mq[0]));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_cnt));
  endtask

  // Drive one cycle of inputs, advance model and DUT, then compare.
  task automatic cycle(input logic [N-1:0] s, input logic [N*W-1:0] d,
                       input logic v, input logic r, input logic c, input string tag);
    sel = s; din = d; in_valid = v; out_ready = r; err_clr = c;
    model_step(s, d, v, r, c);
    @(posedge clk); #1;
    check_model(tag);
  endtask

  task automatic apply_reset();
    nreset = 1'b0; sel = '0; din = '0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    mq.delete(); m_err = 1'b0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out", 32'(out), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_err_cnt", 32'(err_cnt), 32'(0));
    nreset = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'(1));
  endtask

  initial begin
    logic [N*W-1:0] d0;
    d0 = {8'h11, 8'h22, 8'hA5, 8'hF0, 8'h0F};

    tbl[0] = '{5'b00100, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 0};
    tbl[1] = '{5'b00100, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0};
    tbl[2] = '{5'b00000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, EC, int'(EC)};
    tbl[3] = '{5'b00011, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, EC, 2 * int'(EC)};
    tbl[4] = '{5'b00001, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, EC, 2 * int'(EC)};
    tbl[5] = '{5'b00010, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, EC, 2 * int'(EC)};
    tbl[6] = '{5'b00001, 1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, EC, 2 * int'(EC)};
    tbl[7] = '{5'b00001, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, EC, 2 * int'(EC)};
    tbl[8] = '{5'b00001, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 0};

    // Directed vectors: basic select, zero/multi-hot, skid fill and drain, clear.
    apply_reset();
    for (int i = 0; i < NV; i++) begin
      cycle(tbl[i].sel, d0, tbl[i].v, tbl[i].r, tbl[i].c, "tbl");
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out", i), 32'(out), 32'(tbl[i].e_out));
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_err_cnt", i), 32'(err_cnt), 32'(tbl[i].e_cnt));
    end

    // Streaming: 100 back-to-back words, one per cycle, in order.
    apply_reset();
    for (int k = 0; k < 100; k++) begin
      logic [N*W-1:0] d;
      int ch;
      ch = k % int'(N);
      d = 40'({$urandom(), $urandom()});
      d[ch*W +: W] = W'(k);
      cycle(N'(1) << ch, d, 1'b1, 1'b1, 1'b0, "stream");
      chk("stream_out", 32'(out), 32'(W'(k)));
      chk("stream_out_valid", 32'(out_valid), 32'(1));
      chk("stream_in_ready", 32'(in_ready), 32'(1));
    end
    cycle('0, '0, 1'b0, 1'b1, 1'b0, "stream_drain");
    chk("stream_drain_valid", 32'(out_valid), 32'(0));

    // Backpressure: two words held, third refused, then drained in order.
    apply_reset();
    cycle(5'b00001, 40'h10, 1'b1, 1'b0, 1'b0, "bp");
    chk("bp0_out", 32'(out), 32'h10);
    chk("bp0_in_ready", 32'(in_ready), 32'(1));
    cycle(5'b00001, 40'h11, 1'b1, 1'b0, 1'b0, "bp");
    chk("bp1_out", 32'(out), 32'h10);
    chk("bp1_in_ready", 32'(in_ready), 32'(0));
    cycle(5'b00001, 40'h12, 1'b1, 1'b0, 1'b0, "bp");
    chk("bp2_out", 32'(out), 32'h10);
    chk("bp2_in_ready", 32'(in_ready), 32'(0));
    cycle(5'b00001, 40'h12, 1'b0, 1'b1, 1'b0, "bp");
    chk("bp3_out", 32'(out), 32'h11);
    chk("bp3_out_valid", 32'(out_valid), 32'(1));
    cycle(5'b00001, 40'h12, 1'b0, 1'b1, 1'b0, "bp");
    chk("bp4_out_valid", 32'(out_valid), 32'(0));

    // Counter saturation, clear, and clear colliding with a violation.
    apply_reset();
    for (int j = 1; j <= 5; j++) begin
      cycle(5'b00011, d0, 1'b1, 1'b1, 1'b0, "sat");
      chk($sformatf("sat%0d_cnt", j), 32'(err_cnt), 32'(EC ? ((j < CNT_MAX) ? j : CNT_MAX) : 0));
    end
    chk("sat_err", 32'(err), 32'(EC));
    cycle(5'b00001, d0, 1'b0, 1'b1, 1'b1, "clr");
    chk("clr_cnt", 32'(err_cnt), 32'(0));
    chk("clr_err", 32'(err), 32'(0));
    cycle(5'b00011, d0, 1'b1, 1'b1, 1'b1, "clrviol");
    chk("clrviol_cnt", 32'(err_cnt), 32'(EC));
    chk("clrviol_err", 32'(err), 32'(EC));

    // Mid-operation reset with two words buffered.
    apply_reset();
    cycle(5'b00011, d0, 1'b1, 1'b0, 1'b0, "mrst");
    cycle(5'b00001, d0, 1'b1, 1'b0, 1'b0, "mrst");
    #3;
    nreset = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'(0));
    chk("mrst_out", 32'(out), 32'(0));
    chk("mrst_err", 32'(err), 32'(0));
    chk("mrst_err_cnt", 32'(err_cnt), 32'(0));
    mq.delete(); m_err = 1'b0; m_cnt = 0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b1;
    #1;
    chk("mrst_rel_in_ready", 32'(in_ready), 32'(1));
    cycle(5'b00100, d0, 1'b1, 1'b1, 1'b0, "mrst_after");
    chk("mrst_after_out", 32'(out), 32'hA5);
    chk("mrst_after_valid", 32'(out_valid), 32'(1));

    // Randomized traffic against the model.
    apply_reset();
    for (int t = 0; t < 3000; t++) begin
      logic [N-1:0]   s;
      logic [N*W-1:0] d;
      int             k;
      k = int'($urandom_range(0, 9));
      if (k < 7)       s = N'(1) << $urandom_range(0, N - 1);
      else if (k == 7) s = '0;
      else             s = N'($urandom());
      d = 40'({$urandom(), $urandom()});
      cycle(s, d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 19) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
